// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// i2c_bus_monitor : passive SCL/SDA decoder -> event strobes and decoded bytes
// Revision        : 1.0
// ============================================================================

module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       p_clock,
  input  logic       p_reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_is_addr_o,
  output logic       ack_o,
  output logic [6:0] addr_o,
  output logic       rw_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADDR   = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;
  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

  // Index 0 carries SCL, index 1 carries SDA through the shared front end.
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0][3:0]             fcnt_q, fcnt_d;
  logic [1:0]                  filt_q, filt_d;
  logic [1:0]                  prev_q;
  logic [1:0]                  line_raw;

  logic [1:0] state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;

  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       bv_q, bv_d;
  logic       err_q, err_d;
  logic [7:0] byte_q, byte_d;
  logic       is_addr_q, is_addr_d;
  logic       ack_q, ack_d;
  logic [6:0] addr_q, addr_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;

  logic scl_f, sda_f, scl_rise, start_det, stop_det;
  logic in_frame, mid_byte, frame_done;

  assign line_raw = {sda_i, scl_i};

  always_comb begin
    fcnt_d = '0;
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) filt_d[i] = sync_q[i][SYNC_STAGES-1];
        else                        fcnt_d[i] = fcnt_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge p_clock) begin
    if (p_reset) begin
      sync_q <= '1;
      fcnt_q <= '0;
      filt_q <= '1;
      prev_q <= '1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], line_raw[i]};
      end
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
      prev_q <= filt_q;
    end
  end

  assign scl_f     = filt_q[0];
  assign sda_f     = filt_q[1];
  assign scl_rise  = scl_f & ~prev_q[0];
  assign start_det = scl_f & prev_q[0] & ~sda_f &  prev_q[1];
  assign stop_det  = scl_f & prev_q[0] &  sda_f & ~prev_q[1];

  assign in_frame   = (state_q == ST_ADDR) || (state_q == ST_DATA);
  // The SCL rise that sets up a START/STOP is itself counted as a bit, so the
  // condition is mid-byte only when an earlier bit of this frame was received.
  assign mid_byte   = in_frame && (bitcnt_q >= 4'd2);
  assign frame_done = in_frame && scl_rise && (bitcnt_q == 4'd8);

  always_ff @(posedge p_clock) begin
    if (p_reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 4'd0;
      shift_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    if (start_det) begin
      state_d  = ST_ADDR;
      bitcnt_d = 4'd0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      bitcnt_d = 4'd0;
    end else if (in_frame && scl_rise) begin
      if (bitcnt_q < 4'd8) begin
        shift_d  = {shift_q[6:0], sda_f};
        bitcnt_d = bitcnt_q + 4'd1;
      end else begin
        bitcnt_d = 4'd0;
        state_d  = sda_f ? ST_WAIT : ST_DATA;
      end
    end
  end

  always_comb begin
    start_d   = start_det;
    stop_d    = stop_det;
    err_d     = (start_det | stop_det) & mid_byte;
    bv_d      = frame_done;
    byte_d    = byte_q;
    is_addr_d = is_addr_q;
    ack_d     = ack_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    if (frame_done) begin
      byte_d    = shift_q;
      ack_d     = ~sda_f;
      is_addr_d = (state_q == ST_ADDR);
      if (state_q == ST_ADDR) begin
        addr_d = shift_q[7:1];
        rw_d   = shift_q[0];
      end
    end
    if (start_det)     busy_d = 1'b1;
    else if (stop_det) busy_d = 1'b0;
  end

  always_ff @(posedge p_clock) begin
    if (p_reset) begin
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      bv_q      <= 1'b0;
      err_q     <= 1'b0;
      byte_q    <= 8'h00;
      is_addr_q <= 1'b0;
      ack_q     <= 1'b0;
      addr_q    <= 7'h00;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      start_q   <= start_d;
      stop_q    <= stop_d;
      bv_q      <= bv_d;
      err_q     <= err_d;
      byte_q    <= byte_d;
      is_addr_q <= is_addr_d;
      ack_q     <= ack_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
    end
  end

  assign start_o        = start_q;
  assign stop_o         = stop_q;
  assign byte_valid_o   = bv_q;
  assign err_o          = err_q;
  assign byte_o         = byte_q;
  assign byte_is_addr_o = is_addr_q;
  assign ack_o          = ack_q;
  assign addr_o         = addr_q;
  assign rw_o           = rw_q;
  assign busy_o         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// tb_i2c_bus_monitor : randomized I2C bus stimulus against a transaction model
// Revision           : 1.0
// ============================================================================

module tb_i2c_bus_monitor;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 3;
  localparam int LAT         = SYNC_STAGES + FILTER_LEN + 1;

  localparam logic [1:0] EV_START = 2'd0;
  localparam logic [1:0] EV_STOP  = 2'd1;
  localparam logic [1:0] EV_BYTE  = 2'd2;

  localparam int P_IDLE   = 0;
  localparam int P_ADDR   = 1;
  localparam int P_DATA   = 2;
  localparam int P_IGNORE = 3;

  logic       p_clock = 1'b0;
  logic       p_reset = 1'b1;
  logic       scl_i   = 1'b1;
  logic       sda_i   = 1'b1;
  logic       start_o, stop_o, byte_valid_o, byte_is_addr_o, ack_o, rw_o, busy_o, err_o;
  logic [7:0] byte_o;
  logic [6:0] addr_o;
  logic [22:0] out_vec;

  always #5 p_clock = ~p_clock;

  i2c_bus_monitor #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) dut (
    .p_clock        (p_clock),
    .p_reset        (p_reset),
    .scl_i          (scl_i),
    .sda_i          (sda_i),
    .start_o        (start_o),
    .stop_o         (stop_o),
    .byte_valid_o   (byte_valid_o),
    .byte_o         (byte_o),
    .byte_is_addr_o (byte_is_addr_o),
    .ack_o          (ack_o),
    .addr_o         (addr_o),
    .rw_o           (rw_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  assign out_vec = {start_o, stop_o, byte_valid_o, err_o, busy_o, byte_o,
                    byte_is_addr_o, ack_o, addr_o, rw_o};

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic [1:0] kind;
    logic       err;
    logic [7:0] data;
    logic       ack;
    logic       is_addr;
    logic [6:0] addr;
    logic       rw;
    logic       busy;
  } ev_t;

  ev_t        exp_q[$];
  int         m_phase;
  bit         m_bits[$];
  logic [7:0] h_byte;
  logic       h_ack, h_is_addr, h_rw, h_busy;
  logic [6:0] h_addr;

  task automatic m_reset();
    m_phase = P_IDLE;
    m_bits.delete();
    exp_q.delete();
    h_byte = 8'h00; h_ack = 1'b0; h_is_addr = 1'b0; h_addr = 7'h00; h_rw = 1'b0; h_busy = 1'b0;
  endtask

  task automatic push_ev(input logic [1:0] k, input logic err);
    ev_t e;
    e.kind = k; e.err = err; e.data = h_byte; e.ack = h_ack; e.is_addr = h_is_addr;
    e.addr = h_addr; e.rw = h_rw; e.busy = h_busy;
    exp_q.push_back(e);
  endtask

  task automatic m_cond(input logic [1:0] k);
    logic err;
    err = (m_phase == P_ADDR || m_phase == P_DATA) && (m_bits.size() != 0);
    h_busy = (k == EV_START);
    push_ev(k, err);
    m_phase = (k == EV_START) ? P_ADDR : P_IDLE;
    m_bits.delete();
  endtask

  task automatic m_bit(input bit b);
    int v;
    if (m_phase == P_ADDR || m_phase == P_DATA) begin
      m_bits.push_back(b);
      if (m_bits.size() == 9) begin
        v = 0;
        for (int i = 0; i < 8; i++) v = v * 2 + int'(m_bits[i]);
        h_byte    = 8'(v);
        h_ack     = (m_bits[8] == 1'b0);
        h_is_addr = (m_phase == P_ADDR);
        if (m_phase == P_ADDR) begin
          h_addr = 7'(v / 2);
          h_rw   = 1'(v % 2);
        end
        push_ev(EV_BYTE, 1'b0);
        m_phase = h_ack ? P_DATA : P_IGNORE;
        m_bits.delete();
      end
    end
  endtask

  // ---------------- bus drivers ----------------
  int cyc = 0;
  always @(posedge p_clock) cyc <= cyc + 1;

  bit lat_armed = 1'b0;
  int t_start   = 0;

  task automatic hold(input int n);
    repeat (n) @(posedge p_clock);
    #1;
  endtask

  function automatic int ph();
    return int'($urandom_range(FILTER_LEN + 6, FILTER_LEN + 2));
  endfunction

  task automatic drv_bit(input logic b, input logic glitch);
    sda_i = b;
    hold(ph());
    scl_i = 1'b1;
    m_bit(b);
    if (glitch && FILTER_LEN > 1) begin
      hold(ph());
      sda_i = ~b;
      hold(int'($urandom_range(FILTER_LEN - 1, 1)));
      sda_i = b;
    end
    hold(ph());
    scl_i = 1'b0;
    hold(ph());
  endtask

  task automatic drv_byte(input logic [7:0] v, input logic ack, input logic [7:0] gmask);
    for (int i = 7; i >= 0; i--) drv_bit(v[i], gmask[i]);
    drv_bit(~ack, 1'b0);
  endtask

  task automatic drv_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) drv_bit(v[7-i], 1'b0);
  endtask

  task automatic drv_start();
    if (!scl_i) begin
      sda_i = 1'b1;
      hold(ph());
      scl_i = 1'b1;
      hold(ph());
    end
    sda_i   = 1'b0;
    t_start = cyc;
    m_cond(EV_START);
    hold(ph());
    scl_i = 1'b0;
    hold(ph());
  endtask

  task automatic drv_stop();
    if (scl_i) begin
      scl_i = 1'b0;
      hold(ph());
    end
    sda_i = 1'b0;
    hold(ph());
    scl_i = 1'b1;
    hold(ph());
    sda_i = 1'b1;
    m_cond(EV_STOP);
    hold(ph());
  endtask

  task automatic idle_glitch(input int len);
    sda_i = 1'b0;
    hold(len);
    sda_i = 1'b1;
    hold(ph());
  endtask

  task automatic drain(input string tag);
    hold(LAT + 12);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  ev_t        mon_e;
  logic [1:0] mon_kind;
  int         n_ev = 0;
  int         n_bv = 0;

  always @(negedge p_clock) begin
    if (!p_reset) begin
      if (err_o && !start_o && !stop_o) check_eq("err_without_condition", 32'(err_o), 0);
      if (start_o || stop_o || byte_valid_o) begin
        n_ev++;
        if (byte_valid_o) n_bv++;
        check_eq("strobes_per_cycle", 32'(start_o) + 32'(stop_o) + 32'(byte_valid_o), 1);
        mon_kind = start_o ? EV_START : (stop_o ? EV_STOP : EV_BYTE);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event", 32'(mon_kind) + 32'd1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("ev_kind",    32'(mon_kind),       32'(mon_e.kind));
          check_eq("ev_err",     32'(err_o),          32'(mon_e.err));
          check_eq("ev_byte",    32'(byte_o),         32'(mon_e.data));
          check_eq("ev_ack",     32'(ack_o),          32'(mon_e.ack));
          check_eq("ev_is_addr", 32'(byte_is_addr_o), 32'(mon_e.is_addr));
          check_eq("ev_addr",    32'(addr_o),         32'(mon_e.addr));
          check_eq("ev_rw",      32'(rw_o),           32'(mon_e.rw));
          check_eq("ev_busy",    32'(busy_o),         32'(mon_e.busy));
          if (start_o && lat_armed) begin
            check_eq("start_latency", 32'(cyc - t_start), LAT);
            lat_armed = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int n_before;
  int nf;
  bit trunc;

  initial begin
    m_reset();
    hold(3);
    @(negedge p_clock);
    check_eq("reset_outputs", 32'(out_vec), 0);
    @(posedge p_clock);
    #1;
    p_reset = 1'b0;
    hold(12);

    // Address write with data
    lat_armed = 1'b1;
    drv_start();
    drv_byte(8'hCC, 1'b1, 8'h00);
    check_eq("t1_addr_addr", 32'(addr_o), 32'h66);
    check_eq("t1_addr_rw",   32'(rw_o),   0);
    drv_byte(8'hA5, 1'b1, 8'h00);
    drv_stop();
    drain("t1");
    check_eq("t1_byte",    32'(byte_o),         32'hA5);
    check_eq("t1_is_addr", 32'(byte_is_addr_o), 0);
    check_eq("t1_busy",    32'(busy_o),         0);
    check_eq("t1_latency_seen", 32'(lat_armed), 0);

    // Address NACK followed by ignored bits
    n_before = n_bv;
    drv_start();
    drv_byte(8'h05, 1'b0, 8'h00);
    drv_bits(8'(($urandom)), 8);
    drv_stop();
    drain("t2");
    check_eq("t2_byte_valids", 32'(n_bv - n_before), 1);
    check_eq("t2_addr", 32'(addr_o), 32'h02);
    check_eq("t2_rw",   32'(rw_o),   1);
    check_eq("t2_ack",  32'(ack_o),  0);

    // Repeated START
    drv_start();
    drv_byte(8'hCC, 1'b1, 8'h00);
    drv_start();
    check_eq("t3_busy_held", 32'(busy_o), 1);
    drv_byte(8'hCD, 1'b1, 8'h00);
    check_eq("t3_rw",   32'(rw_o),   1);
    check_eq("t3_addr", 32'(addr_o), 32'h66);
    drv_stop();
    drain("t3");

    // Glitch rejection on an idle bus and inside data bits
    n_before = n_ev;
    idle_glitch(FILTER_LEN - 1);
    idle_glitch(1);
    drain("t4a");
    check_eq("t4_glitch_events", 32'(n_ev - n_before), 0);
    drv_start();
    drv_byte(8'h5A, 1'b1, 8'h00);
    drv_byte(8'h3C, 1'b1, 8'hFF);
    drv_stop();
    drain("t4b");
    check_eq("t4_byte", 32'(byte_o), 32'h3C);

    // Mid-byte STOP
    drv_start();
    drv_byte(8'hCC, 1'b1, 8'h00);
    drv_bits(8'h90, 4);
    drv_stop();
    drain("t5");
    check_eq("t5_byte_kept", 32'(byte_o), 32'hCC);

    // Reset in the middle of an address byte
    drv_start();
    drv_bits(8'hA0, 3);
    sda_i = 1'b1;
    hold(ph());
    drain("t6a");
    n_before = n_ev;
    p_reset = 1'b1;
    hold(1);
    p_reset = 1'b0;
    m_reset();
    @(negedge p_clock);
    check_eq("t6_reset_outputs", 32'(out_vec), 0);
    hold(20);
    scl_i = 1'b1;
    hold(20);
    check_eq("t6_silent_abort", 32'(n_ev - n_before), 0);
    drv_start();
    drv_byte(8'h3C, 1'b1, 8'h00);
    drv_stop();
    drain("t6b");
    check_eq("t6_addr", 32'(addr_o), 32'h1E);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(3, 0) == 0) idle_glitch(int'($urandom_range(FILTER_LEN - 1, 1)));
      drv_start();
      nf    = int'($urandom_range(3, 1));
      trunc = 1'b0;
      for (int f = 0; f < nf && !trunc; f++) begin
        if ($urandom_range(5, 0) == 0) begin
          drv_bits(8'($urandom), int'($urandom_range(7, 1)));
          trunc = 1'b1;
        end else begin
          drv_byte(8'($urandom), $urandom_range(3, 0) != 0,
                   ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00);
        end
      end
      if ($urandom_range(2, 0) == 0) begin
        drv_start();
        drv_byte(8'($urandom), 1'b1, 8'h00);
      end
      drv_stop();
      drain("rand");
    end

    check_eq("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
